// File: rtl/boot_sequencer_if.sv
// Loader stream (valid/ready) plus the instruction and data BRAM write ports of the boot sequencer.
interface boot_sequencer_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [31:0]           s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic [ADDR_WIDTH-1:0] i_w_addr;
    logic [31:0]           i_w_dat;
    logic                  i_w_enb;
    logic [ADDR_WIDTH-1:0] d_w_addr;
    logic [31:0]           d_w_dat;
    logic                  d_w_enb;

    modport master (
        output s_data, s_valid,
        input  s_ready, i_w_addr, i_w_dat, i_w_enb, d_w_addr, d_w_dat, d_w_enb
    );

    modport slave (
        input  s_data, s_valid,
        output s_ready, i_w_addr, i_w_dat, i_w_enb, d_w_addr, d_w_dat, d_w_enb
    );
endinterface

// File: rtl/boot_sequencer.sv
// Boot controller for rv32i_sc: loads header, data and instruction words from a stream into the BRAMs, then releases the core.
// Optional trailer checksum stage (CHECK state) is compiled in by defining BOOT_CHECKSUM_EN.
module boot_sequencer #(
    parameter int         ADDR_WIDTH = 10,
    parameter logic [7:0] MAGIC      = 8'hB0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    boot_sequencer_if.slave bus,
    output logic            d_bram_init_done,
    output logic            core_rst,
    output logic            pc_stall,
    output logic            i_r_enb,
    output logic            rd_enbl,
    output logic            busy,
    output logic            err
);

`ifdef BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HEADER, LOAD_DATA, LOAD_INSTR, CHECK, RELEASE, RUN, ERROR} state_t;
`else
    typedef enum logic [2:0] {IDLE, HEADER, LOAD_DATA, LOAD_INSTR, RELEASE, RUN, ERROR} state_t;
`endif

    typedef struct packed {
        logic ready;
        logic busy;
        logic stall;
        logic init_done;
        logic core_rst;
        logic run_en;
        logic err;
    } flags_t;

    state_t                state, nxt;
    flags_t                flags_p0;
    logic                  beat;
    logic [7:0]            cnt, d_cnt, i_cnt;
    logic [ADDR_WIDTH-1:0] d_w_addr_p1, i_w_addr_p1;
    logic [31:0]           d_w_dat_p1, i_w_dat_p1;
    logic                  d_w_enb_p1, i_w_enb_p1;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0]           sum;
`endif

    // Outputs are a function of the state being entered, so they change on the same edge as the state.
    function automatic flags_t decode(state_t s);
        flags_t f;
        f       = '0;
        f.stall = 1'b1;
        case (s)
            HEADER, LOAD_DATA, LOAD_INSTR: begin f.ready = 1'b1; f.busy = 1'b1; end
`ifdef BOOT_CHECKSUM_EN
            CHECK:   begin f.ready = 1'b1; f.busy = 1'b1; end
`endif
            RELEASE: begin f.busy = 1'b1; f.init_done = 1'b1; f.core_rst = 1'b1; end
            RUN:     begin f.stall = 1'b0; f.init_done = 1'b1; f.run_en = 1'b1; end
            ERROR:   f.err = 1'b1;
            default: ;
        endcase
        return f;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] word_addr(logic [7:0] k);
        logic [9:0] byte_addr;
        byte_addr = {k, 2'b00};
        return ADDR_WIDTH'(byte_addr);
    endfunction

    assign beat = bus.s_valid && bus.s_ready;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:       if (start) nxt = HEADER;
            HEADER: begin
                if (beat) begin
                    if (bus.s_data[31:24] != MAGIC || bus.s_data[7:0] == 8'd0) nxt = ERROR;
                    else if (bus.s_data[15:8] == 8'd0)                         nxt = LOAD_INSTR;
                    else                                                       nxt = LOAD_DATA;
                end
            end
            LOAD_DATA:  if (beat && cnt == d_cnt - 8'd1) nxt = LOAD_INSTR;
`ifdef BOOT_CHECKSUM_EN
            LOAD_INSTR: if (beat && cnt == i_cnt - 8'd1) nxt = CHECK;
            CHECK:      if (beat) nxt = (bus.s_data == sum) ? RELEASE : ERROR;
`else
            LOAD_INSTR: if (beat && cnt == i_cnt - 8'd1) nxt = RELEASE;
`endif
            RELEASE:    nxt = RUN;
            RUN, ERROR: if (start) nxt = HEADER;
            default:    nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            flags_p0    <= decode(IDLE);
            cnt         <= '0;
            d_cnt       <= '0;
            i_cnt       <= '0;
            d_w_enb_p1  <= 1'b0;
            i_w_enb_p1  <= 1'b0;
            d_w_addr_p1 <= '0;
            i_w_addr_p1 <= '0;
            d_w_dat_p1  <= '0;
            i_w_dat_p1  <= '0;
`ifdef BOOT_CHECKSUM_EN
            sum         <= '0;
`endif
        end else begin
            state    <= nxt;
            flags_p0 <= decode(nxt);
            cnt      <= (nxt != state) ? 8'd0 : (beat ? cnt + 8'd1 : cnt);
            if (beat && state == HEADER) begin
                d_cnt <= bus.s_data[15:8];
                i_cnt <= bus.s_data[7:0];
            end
            // Write stage: accepted beat lands on the BRAM port one cycle later
            d_w_enb_p1 <= beat && state == LOAD_DATA;
            i_w_enb_p1 <= beat && state == LOAD_INSTR;
            if (beat && state == LOAD_DATA) begin
                d_w_addr_p1 <= word_addr(cnt);
                d_w_dat_p1  <= bus.s_data;
            end
            if (beat && state == LOAD_INSTR) begin
                i_w_addr_p1 <= word_addr(cnt);
                i_w_dat_p1  <= bus.s_data;
            end
`ifdef BOOT_CHECKSUM_EN
            if (nxt == HEADER && state != HEADER)
                sum <= '0;
            else if (beat && (state == LOAD_DATA || state == LOAD_INSTR))
                sum <= sum + bus.s_data;
`endif
        end
    end

    assign bus.s_ready      = flags_p0.ready;
    assign bus.d_w_enb      = d_w_enb_p1;
    assign bus.d_w_addr     = d_w_addr_p1;
    assign bus.d_w_dat      = d_w_dat_p1;
    assign bus.i_w_enb      = i_w_enb_p1;
    assign bus.i_w_addr     = i_w_addr_p1;
    assign bus.i_w_dat      = i_w_dat_p1;
    assign d_bram_init_done = flags_p0.init_done;
    assign core_rst         = flags_p0.core_rst;
    assign pc_stall         = flags_p0.stall;
    assign i_r_enb          = flags_p0.run_en;
    assign rd_enbl          = flags_p0.run_en;
    assign busy             = flags_p0.busy;
    assign err              = flags_p0.err;

endmodule

// File: tb/tb_boot_sequencer.sv
// Randomized self-checking bench for boot_sequencer; BRAM writes are logged and compared with a list-based load model.
module tb_boot_sequencer;
    localparam int         AW    = 10;
    localparam logic [7:0] MAGIC = 8'hB0;

    logic clk = 1'b0;
    logic rst, start;
    logic d_bram_init_done, core_rst, pc_stall, i_r_enb, rd_enbl, busy, err;

    int checks = 0;
    int errors = 0;

    boot_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

    boot_sequencer #(.ADDR_WIDTH(AW), .MAGIC(MAGIC)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .bus              (bus),
        .d_bram_init_done (d_bram_init_done),
        .core_rst         (core_rst),
        .pc_stall         (pc_stall),
        .i_r_enb          (i_r_enb),
        .rd_enbl          (rd_enbl),
        .busy             (busy),
        .err              (err)
    );

    always #5 clk = ~clk;

    // Write log, sampled mid-cycle
    logic [AW-1:0] d_addr_q[$], i_addr_q[$];
    logic [31:0]   d_dat_q[$],  i_dat_q[$];
    int            rel_cycles, rel_with_iw;

    always @(negedge clk) begin
        if (bus.d_w_enb) begin d_addr_q.push_back(bus.d_w_addr); d_dat_q.push_back(bus.d_w_dat); end
        if (bus.i_w_enb) begin i_addr_q.push_back(bus.i_w_addr); i_dat_q.push_back(bus.i_w_dat); end
        if (core_rst) rel_cycles++;
        if (core_rst && bus.i_w_enb) rel_with_iw++;
    end

    task automatic clear_log();
        d_addr_q.delete(); d_dat_q.delete(); i_addr_q.delete(); i_dat_q.delete();
        rel_cycles  = 0;
        rel_with_iw = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic put(input logic [31:0] w, input int gap);
        logic ok;
        int   n;
        repeat (gap) begin bus.s_valid = 1'b0; @(posedge clk); #1; end
        bus.s_data  = w;
        bus.s_valid = 1'b1;
        n = 0;
        do begin
            ok = bus.s_ready;
            @(posedge clk); #1;
            n++;
        end while (!ok && n < 200);
        bus.s_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL handshake: word %08h not accepted after %0d cycles (required acceptance)", w, n);
        end
    endtask

    // Reference model: word k of a phase belongs at byte address 4*k, in stream order.
    task automatic check_log(input string name, input logic [AW-1:0] aq[$], input logic [31:0] dq[$],
                             input logic [31:0] exp_w[$]);
        logic [AW-1:0] ea;
        checks++;
        if (aq.size() !== exp_w.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d writes, expected %0d", name, aq.size(), exp_w.size());
        end
        for (int k = 0; k < exp_w.size() && k < aq.size(); k++) begin
            ea = AW'((4 * k) % (1 << AW));
            checks++;
            if (aq[k] !== ea || dq[k] !== exp_w[k]) begin
                errors++;
                $display("FAIL %s_write[%0d]: got addr %0h data %08h, expected addr %0h data %08h",
                         name, k, aq[k], dq[k], ea, exp_w[k]);
            end
        end
    endtask

    task automatic run_load(input logic [7:0] dc, input logic [7:0] ic, input logic [31:0] w[$],
                            input int gmin, input int gmax, input logic [31:0] tdelta);
        logic [31:0] dexp[$], iexp[$];
        logic [31:0] total;
        logic        good;
        int          n;
        total = 32'd0;
        good  = 1'b1;
`ifdef BOOT_CHECKSUM_EN
        good = (tdelta == 32'd0);
`endif
        clear_log();
        pulse_start();
        checks++;
        if (bus.s_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL header_ready: got s_ready=%b busy=%b, expected 1 1", bus.s_ready, busy);
        end
        put({MAGIC, 8'h00, dc, ic}, $urandom_range(gmin, gmax));
        for (int k = 0; k < int'(dc) + int'(ic); k++) begin
            if (k < int'(dc)) dexp.push_back(w[k]); else iexp.push_back(w[k]);
            total = total + w[k];
            put(w[k], $urandom_range(gmin, gmax));
        end
`ifdef BOOT_CHECKSUM_EN
        put(total + tdelta, $urandom_range(gmin, gmax));
`endif
        n = 0;
        while (n < 20 && (good ? pc_stall : !err)) begin @(posedge clk); #1; n++; end
        repeat (2) begin @(posedge clk); #1; end
        check_log("data", d_addr_q, d_dat_q, dexp);
        check_log("instr", i_addr_q, i_dat_q, iexp);
        checks++;
        if (good) begin
            if ({pc_stall, d_bram_init_done, i_r_enb, rd_enbl, busy, err, rel_cycles == 1} !== 7'b0111001) begin
                errors++;
                $display("FAIL run_state: got stall=%b init=%b ir=%b rd=%b busy=%b err=%b rel_cycles=%0d, expected 0 1 1 1 0 0 1",
                         pc_stall, d_bram_init_done, i_r_enb, rd_enbl, busy, err, rel_cycles);
            end
        end else begin
            if ({err, pc_stall, d_bram_init_done, bus.s_ready, rel_cycles == 0} !== 5'b11001) begin
                errors++;
                $display("FAIL error_state: got err=%b stall=%b init=%b ready=%b rel_cycles=%0d, expected 1 1 0 0 0",
                         err, pc_stall, d_bram_init_done, bus.s_ready, rel_cycles);
            end
        end
`ifndef BOOT_CHECKSUM_EN
        checks++;
        if (rel_with_iw !== 1) begin
            errors++;
            $display("FAIL release_timing: last instr write overlapped release %0d times, expected 1", rel_with_iw);
        end
`endif
    endtask

    task automatic rand_load(input logic [7:0] dc, input logic [7:0] ic, input int gmin, input int gmax);
        logic [31:0] w[$];
        for (int k = 0; k < int'(dc) + int'(ic); k++) w.push_back($urandom);
        run_load(dc, ic, w, gmin, gmax, 32'd0);
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.s_ready, bus.d_w_enb, bus.i_w_enb, d_bram_init_done, core_rst, pc_stall,
             i_r_enb, rd_enbl, busy, err} !== 10'b0000010000) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b dw=%b iw=%b init=%b crst=%b stall=%b ir=%b rd=%b busy=%b err=%b, expected only stall=1",
                     bus.s_ready, bus.d_w_enb, bus.i_w_enb, d_bram_init_done, core_rst, pc_stall,
                     i_r_enb, rd_enbl, busy, err);
        end
        checks++;
        if ({bus.d_w_addr, bus.d_w_dat, bus.i_w_addr, bus.i_w_dat} !== '0) begin
            errors++;
            $display("FAIL reset_ports: got d_addr=%0h d_dat=%08h i_addr=%0h i_dat=%08h, expected all 0",
                     bus.d_w_addr, bus.d_w_dat, bus.i_w_addr, bus.i_w_dat);
        end
    endtask

    task automatic test_basic_load();
        rand_load(8'd3, 8'd16, 0, 0);
    endtask

    task automatic test_bad_magic();
        clear_log();
        pulse_start();
        put(32'hA000_0110, 0);
        checks++;
        if (err !== 1'b1 || bus.s_ready !== 1'b0 || pc_stall !== 1'b1) begin
            errors++;
            $display("FAIL bad_magic: got err=%b ready=%b stall=%b, expected 1 0 1", err, bus.s_ready, pc_stall);
        end
        bus.s_data  = $urandom;
        bus.s_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        bus.s_valid = 1'b0;
        checks++;
        if (d_addr_q.size() + i_addr_q.size() !== 0 || err !== 1'b1) begin
            errors++;
            $display("FAIL bad_magic_hold: got %0d writes err=%b, expected 0 writes err=1",
                     d_addr_q.size() + i_addr_q.size(), err);
        end
        pulse_start();
        checks++;
        if (err !== 1'b0 || bus.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL err_clear: got err=%b ready=%b, expected 0 1", err, bus.s_ready);
        end
    endtask

    task automatic test_zero_icnt();
        pulse_start();
        put({MAGIC, 8'h00, 8'h04, 8'h00}, 0);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL zero_icnt: got err=%b, expected 1", err);
        end
    endtask

    task automatic test_no_data_toggle();
        rand_load(8'd0, 8'd2, 1, 1);
    endtask

    task automatic test_rst_mid_load();
        pulse_start();
        put({MAGIC, 8'h00, 8'h00, 8'h0A}, 0);
        for (int k = 0; k < 5; k++) put($urandom, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({pc_stall, busy, bus.s_ready, bus.d_w_enb, bus.i_w_enb, err} !== 6'b100000) begin
            errors++;
            $display("FAIL rst_abort: got stall=%b busy=%b ready=%b dw=%b iw=%b err=%b, expected 1 0 0 0 0 0",
                     pc_stall, busy, bus.s_ready, bus.d_w_enb, bus.i_w_enb, err);
        end
        rst = 1'b0;
    endtask

    task automatic test_restart_from_run();
        pulse_start();
        checks++;
        if ({pc_stall, d_bram_init_done, i_r_enb, rd_enbl, busy, bus.s_ready} !== 6'b100011) begin
            errors++;
            $display("FAIL restart: got stall=%b init=%b ir=%b rd=%b busy=%b ready=%b, expected 1 0 0 0 1 1",
                     pc_stall, d_bram_init_done, i_r_enb, rd_enbl, busy, bus.s_ready);
        end
    endtask

    task automatic test_random_loads();
        for (int t = 0; t < 6; t++)
            rand_load(8'($urandom_range(0, 12)), 8'($urandom_range(1, 12)), 0, $urandom_range(0, 2));
        rand_load(8'd1, 8'd255, 0, 0);
    endtask

`ifdef BOOT_CHECKSUM_EN
    task automatic test_checksum();
        logic [31:0] w[$];
        w = '{32'd1, 32'd2, 32'd3};
        run_load(8'd2, 8'd1, w, 0, 0, 32'd0);
        run_load(8'd2, 8'd1, w, 0, 0, 32'd1);
    endtask
`endif

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        bus.s_data  = '0;
        bus.s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_basic_load();
        test_restart_from_run();
        test_bad_magic();
        test_no_data_toggle();
        test_zero_icnt();
        test_rst_mid_load();
        test_random_loads();
`ifdef BOOT_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
